// File: rtl/context_save_unit.sv
// Process context table plus round-robin scheduler: captures preempted PCs per
// process slot and, on request, returns the next ready process and its resume PC.
module context_save_unit #(
  parameter int          NUM_PROC = 4,
  parameter int          PID_W    = 2,
  parameter logic [31:0] OS_PC    = 32'd3
) (
  input  logic                clock,
  input  logic                reset_geral_n,
  input  logic                flag_faz_preempcao,
  input  logic [31:0]         salva_PC,
  input  logic [PID_W-1:0]    prog_atual,
  input  logic                start_proc,
  input  logic [PID_W-1:0]    start_pid,
  input  logic [31:0]         start_addr,
  input  logic                end_proc,
  input  logic [PID_W-1:0]    end_pid,
  input  logic                sched_req,
  output logic                sched_valid,
  output logic [PID_W-1:0]    sched_pid,
  output logic [31:0]         sched_PC,
  output logic                busy,
  output logic [NUM_PROC-1:0] ready_mask,
  output logic [31:0]         cont_trocas
);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t               state, state_next;
  logic [PID_W-1:0]     ptr, ptr_next;
  logic [PID_W-1:0]     cand, cand_next;
  logic [PID_W-1:0]     cnt, cnt_next;
  logic                 valid_next;
  logic [PID_W-1:0]     pid_next;
  logic [31:0]          pc_next;

  logic                 flag_q;
  logic                 capture;
  logic                 save_ok;
  logic [NUM_PROC-1:0]  ready_bits;
  logic [31:0]          pc_tab [NUM_PROC];

  // Round-robin successor over user slots only; slot 0 is never a candidate.
  function automatic logic [PID_W-1:0] next_slot(input logic [PID_W-1:0] x);
    if (x >= PID_W'(NUM_PROC-1)) return PID_W'(1);
    else return x + PID_W'(1);
  endfunction

  assign capture    = flag_faz_preempcao & ~flag_q;
  assign ready_mask = ready_bits;
  assign busy       = (state == SEARCH);

  always_comb begin
    save_ok = 1'b0;
    for (int i = 1; i < NUM_PROC; i++) begin
      if (capture && prog_atual == PID_W'(i)) save_ok = 1'b1;
    end
  end

  // Context table: per-slot priority save > start > end.
  always_ff @(posedge clock) begin
    if (!reset_geral_n) begin
      flag_q      <= 1'b0;
      cont_trocas <= '0;
      ready_bits  <= '0;
      for (int i = 0; i < NUM_PROC; i++) pc_tab[i] <= '0;
    end else begin
      flag_q <= flag_faz_preempcao;
      if (save_ok) cont_trocas <= cont_trocas + 32'd1;
      for (int i = 1; i < NUM_PROC; i++) begin
        if (capture && prog_atual == PID_W'(i)) begin
          pc_tab[i]     <= salva_PC;
          ready_bits[i] <= 1'b1;
        end else if (start_proc && start_pid == PID_W'(i)) begin
          pc_tab[i]     <= start_addr;
          ready_bits[i] <= 1'b1;
        end else if (end_proc && end_pid == PID_W'(i)) begin
          ready_bits[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    cand_next  = cand;
    cnt_next   = cnt;
    valid_next = 1'b0;
    pid_next   = sched_pid;
    pc_next    = sched_PC;
    case (state)
      IDLE: begin
        if (sched_req) begin
          cand_next  = next_slot(ptr);
          cnt_next   = '0;
          state_next = SEARCH;
        end
      end
      SEARCH: begin
        if (ready_bits[cand]) begin
          valid_next = 1'b1;
          pid_next   = cand;
          pc_next    = pc_tab[cand];
          ptr_next   = cand;
          state_next = IDLE;
        end else if (cnt == PID_W'(NUM_PROC-2)) begin
          // Every user slot examined and none ready: hand control to the OS.
          valid_next = 1'b1;
          pid_next   = '0;
          pc_next    = OS_PC;
          state_next = IDLE;
        end else begin
          cand_next = next_slot(cand);
          cnt_next  = cnt + PID_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_geral_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cand        <= '0;
      cnt         <= '0;
      sched_valid <= 1'b0;
      sched_pid   <= '0;
      sched_PC    <= '0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      cand        <= cand_next;
      cnt         <= cnt_next;
      sched_valid <= valid_next;
      sched_pid   <= pid_next;
      sched_PC    <= pc_next;
    end
  end

endmodule

// File: tb/tb_context_save_unit.sv
// Bench for context_save_unit: vector table of start/end/schedule steps plus
// hand sequences for capture, same-cycle conflicts and reset during search.
module tb_context_save_unit;

  logic        clock = 1'b0;
  logic        reset_geral_n;
  logic        flag_faz_preempcao;
  logic [31:0] salva_PC;
  logic [1:0]  prog_atual;
  logic        start_proc;
  logic [1:0]  start_pid;
  logic [31:0] start_addr;
  logic        end_proc;
  logic [1:0]  end_pid;
  logic        sched_req;
  logic        sched_valid;
  logic [1:0]  sched_pid;
  logic [31:0] sched_PC;
  logic        busy;
  logic [3:0]  ready_mask;
  logic [31:0] cont_trocas;

  context_save_unit dut (
    .clock(clock), .reset_geral_n(reset_geral_n),
    .flag_faz_preempcao(flag_faz_preempcao), .salva_PC(salva_PC), .prog_atual(prog_atual),
    .start_proc(start_proc), .start_pid(start_pid), .start_addr(start_addr),
    .end_proc(end_proc), .end_pid(end_pid), .sched_req(sched_req),
    .sched_valid(sched_valid), .sched_pid(sched_pid), .sched_PC(sched_PC),
    .busy(busy), .ready_mask(ready_mask), .cont_trocas(cont_trocas)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;
  int n_valid = 0;
  logic [33:0] exp_q[$];

  typedef struct {
    logic [3:0]  start_mask;
    logic [31:0] base;
    logic [3:0]  end_mask;
    logic [3:0]  exp_mask;
    logic [1:0]  exp_pid;
    logic [31:0] exp_pc;
    int          exp_lat;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  // Every result pulse must match the oldest outstanding expectation.
  always @(posedge clock) begin
    #1;
    if (sched_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(sched_pid), 32'hFFFF_FFFF);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("sched_pid", 32'(sched_pid), 32'(e[33:32]));
        chk("sched_PC", sched_PC, e[31:0]);
      end
    end
  end

  task automatic clear_inputs;
    flag_faz_preempcao = 1'b0; salva_PC = '0; prog_atual = '0;
    start_proc = 1'b0; start_pid = '0; start_addr = '0;
    end_proc = 1'b0; end_pid = '0; sched_req = 1'b0;
  endtask

  task automatic start_cmd(input logic [1:0] pid, input logic [31:0] addr);
    start_proc = 1'b1; start_pid = pid; start_addr = addr;
    tick;
    start_proc = 1'b0;
  endtask

  task automatic end_cmd(input logic [1:0] pid);
    end_proc = 1'b1; end_pid = pid;
    tick;
    end_proc = 1'b0;
  endtask

  task automatic do_sched(input logic [1:0] pid, input logic [31:0] pc, input int lat_exp);
    int v0, lat, busy_cnt;
    exp_q.push_back({pid, pc});
    v0 = n_valid;
    sched_req = 1'b1;
    tick;
    sched_req = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (n_valid == v0 && lat < 12) begin
      if (busy) busy_cnt++;
      tick;
      lat++;
    end
    if (n_valid == v0) begin
      chk("sched_timeout", 32'(lat), 32'(lat_exp));
      exp_q.delete();
    end else begin
      chk("sched_latency", 32'(lat), 32'(lat_exp));
      chk("busy_cycles", 32'(busy_cnt), 32'(lat_exp - 1));
      chk("busy_after", 32'(busy), 32'd0);
    end
  endtask

  task automatic flag_pulse(input logic [1:0] pid, input logic [31:0] pc, input int cycles);
    flag_faz_preempcao = 1'b1; prog_atual = pid; salva_PC = pc;
    for (int c = 0; c < cycles; c++) tick;
    flag_faz_preempcao = 1'b0;
    tick;
  endtask

  initial begin
    // start_mask, base, end_mask, exp_mask, exp_pid, exp_pc, exp_lat
    vecs[0] = '{4'b0110, 32'd10,  4'b0000, 4'b0110, 2'd1, 32'd10,  2};
    vecs[1] = '{4'b0000, 32'd0,   4'b0000, 4'b0110, 2'd2, 32'd40,  2};
    vecs[2] = '{4'b0000, 32'd0,   4'b0000, 4'b0110, 2'd1, 32'd10,  3};
    vecs[3] = '{4'b0000, 32'd0,   4'b0110, 4'b0000, 2'd0, 32'd3,   4};
    vecs[4] = '{4'b1000, 32'd100, 4'b0000, 4'b1000, 2'd3, 32'd160, 3};
    vecs[5] = '{4'b0010, 32'd5,   4'b1000, 4'b0010, 2'd1, 32'd5,   2};
    vecs[6] = '{4'b0000, 32'd0,   4'b0000, 4'b0010, 2'd1, 32'd5,   4};
    vecs[7] = '{4'b1110, 32'd200, 4'b0000, 4'b1110, 2'd2, 32'd230, 2};
    vecs[8] = '{4'b0000, 32'd0,   4'b0000, 4'b1110, 2'd3, 32'd260, 2};
    vecs[9] = '{4'b0000, 32'd0,   4'b0000, 4'b1110, 2'd1, 32'd200, 2};

    clear_inputs();
    reset_geral_n = 1'b0;

    // Reset with random inputs
    for (int c = 0; c < 2; c++) begin
      flag_faz_preempcao = 1'($urandom_range(0, 1));
      salva_PC = $urandom; prog_atual = 2'($urandom_range(0, 3));
      start_proc = 1'($urandom_range(0, 1)); start_pid = 2'($urandom_range(0, 3));
      start_addr = $urandom; end_proc = 1'($urandom_range(0, 1));
      end_pid = 2'($urandom_range(0, 3)); sched_req = 1'($urandom_range(0, 1));
      tick;
    end
    chk("rst_valid", 32'(sched_valid), 32'd0);
    chk("rst_pid", 32'(sched_pid), 32'd0);
    chk("rst_pc", sched_PC, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mask", 32'(ready_mask), 32'd0);
    chk("rst_cont", cont_trocas, 32'd0);

    // Flag already high at reset release counts as an edge
    clear_inputs();
    flag_faz_preempcao = 1'b1; prog_atual = 2'd1; salva_PC = 32'd100;
    reset_geral_n = 1'b1;
    tick;
    chk("release_cont", cont_trocas, 32'd1);
    chk("release_mask", 32'(ready_mask), 32'b0010);
    clear_inputs();
    reset_geral_n = 1'b0;
    tick; tick;
    reset_geral_n = 1'b1;
    tick;

    for (int i = 0; i < 10; i++) begin
      for (int s = 1; s < 4; s++)
        if (vecs[i].start_mask[s]) start_cmd(2'(s), vecs[i].base + 32'(30 * (s - 1)));
      for (int s = 1; s < 4; s++)
        if (vecs[i].end_mask[s]) end_cmd(2'(s));
      chk("vec_mask", 32'(ready_mask), 32'(vecs[i].exp_mask));
      do_sched(vecs[i].exp_pid, vecs[i].exp_pc, vecs[i].exp_lat);
    end

    // Capture: flag held 3 cycles counts once
    flag_faz_preempcao = 1'b1; prog_atual = 2'd2; salva_PC = 32'd57;
    tick;
    chk("cap_cont_first", cont_trocas, 32'd1);
    tick; tick;
    chk("cap_cont_held", cont_trocas, 32'd1);
    flag_faz_preempcao = 1'b0;
    tick;
    end_cmd(2'd1);
    end_cmd(2'd3);
    chk("cap_mask", 32'(ready_mask), 32'b0100);
    do_sched(2'd2, 32'd57, 2);
    flag_pulse(2'd0, 32'd99, 3);
    chk("cap_os_cont", cont_trocas, 32'd1);
    chk("cap_os_mask", 32'(ready_mask), 32'b0100);
    do_sched(2'd2, 32'd57, 4);

    // Same-cycle conflicts
    flag_faz_preempcao = 1'b1; prog_atual = 2'd1; salva_PC = 32'd77;
    end_proc = 1'b1; end_pid = 2'd1;
    tick;
    clear_inputs();
    chk("save_end_mask", 32'(ready_mask), 32'b0110);
    chk("save_end_cont", cont_trocas, 32'd2);
    start_proc = 1'b1; start_pid = 2'd3; start_addr = 32'd300;
    end_proc = 1'b1; end_pid = 2'd3;
    tick;
    clear_inputs();
    chk("start_end_mask", 32'(ready_mask), 32'b1110);
    flag_faz_preempcao = 1'b1; prog_atual = 2'd1; salva_PC = 32'd88;
    start_proc = 1'b1; start_pid = 2'd1; start_addr = 32'd500;
    tick;
    clear_inputs();
    chk("save_start_cont", cont_trocas, 32'd3);
    tick;
    do_sched(2'd3, 32'd300, 2);
    do_sched(2'd1, 32'd88, 2);
    flag_faz_preempcao = 1'b1; prog_atual = 2'd2; salva_PC = 32'd111;
    start_proc = 1'b1; start_pid = 2'd3; start_addr = 32'd400;
    end_proc = 1'b1; end_pid = 2'd1;
    tick;
    clear_inputs();
    chk("multi_mask", 32'(ready_mask), 32'b1100);
    chk("multi_cont", cont_trocas, 32'd4);
    tick;
    do_sched(2'd2, 32'd111, 2);
    do_sched(2'd3, 32'd400, 2);

    // Reset in the second SEARCH cycle aborts the search
    end_cmd(2'd2);
    end_cmd(2'd3);
    begin
      int v0;
      v0 = n_valid;
      sched_req = 1'b1;
      tick;
      sched_req = 1'b0;
      chk("abort_busy1", 32'(busy), 32'd1);
      tick;
      chk("abort_busy2", 32'(busy), 32'd1);
      reset_geral_n = 1'b0;
      tick;
      chk("abort_busy_after", 32'(busy), 32'd0);
      chk("abort_valid_after", 32'(sched_valid), 32'd0);
      reset_geral_n = 1'b1;
      for (int c = 0; c < 5; c++) tick;
      chk("abort_no_pulse", 32'(n_valid - v0), 32'd0);
      chk("abort_mask", 32'(ready_mask), 32'd0);
    end
    do_sched(2'd0, 32'd3, 4);

    tick; tick;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/context_save_unit.md
# context_save_unit

Process context table and round-robin scheduler placed directly downstream of the program counter. It captures the return address the program counter emits on every preemption (`salva_PC` qualified by `flag_faz_preempcao`) into a per-process slot. When the OS routine asks for the next process, the block scans the slots round-robin and returns the process id and resume address to load into the program counter.

## Interface
- `NUM_PROC`, default 4: number of slots; slot 0 is the OS, slots 1..NUM_PROC-1 are user processes.
- `PID_W`, default 2: process id width; `NUM_PROC` ≤ 2^PID_W.
- `OS_PC`, default 3: address returned when no user process is ready.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset_geral_n`  in  1  reset, synchronous, active-low.
- `flag_faz_preempcao`  in  1  preemption flag from the program counter.
- `salva_PC`  in  32  interrupted PC, valid while the flag is high.
- `prog_atual`  in  PID_W  id of the process that was running when preempted.
- `start_proc`  in  1  one-cycle command: load a new process.
- `start_pid`  in  PID_W  slot for `start_proc`.
- `start_addr`  in  32  entry address for `start_proc`.
- `end_proc`  in  1  one-cycle command: retire a process.
- `end_pid`  in  PID_W  slot for `end_proc`.
- `sched_req`  in  1  OS request for the next process.
- `sched_valid`  out  1  one-cycle pulse: the result is valid.
- `sched_pid`  out  PID_W  selected process; 0 means none ready.
- `sched_PC`  out  32  resume address of the selected process.
- `busy`  out  1  high while a search is in progress.
- `ready_mask`  out  NUM_PROC  per-slot ready bits; bit 0 is always 0.
- `cont_trocas`  out  32  count of captured preemptions.

## Operation
- **Table:** per slot there is a ready bit and a 32-bit PC. Slot 0 is never written.
- **Save:**
  - A capture fires on a 0→1 edge of `flag_faz_preempcao`. The edge register resets to 0, so a flag held high out of reset counts as an edge.
  - On capture with `prog_atual` in 1..NUM_PROC-1, the slot's PC is set to `salva_PC`, its ready bit is set to 1, and `cont_trocas` increments modulo 2^32.
  - If `prog_atual` is 0 or ≥ NUM_PROC, the capture is ignored and nothing is counted.
  - A flag held high for several cycles produces exactly one capture.
- **Start:** sets the slot's PC to `start_addr` and its ready bit to 1. Ignored for pid 0 or pid ≥ NUM_PROC.
- **End:** clears the slot's ready bit. The PC is left unchanged.
- **Same-slot conflicts** within one cycle are resolved with priority save > start > end. Commands to different slots all take effect.
- **Command timing:** save, start and end are accepted in every FSM state.
- **FSM states:** IDLE and SEARCH.
  - IDLE: when `sched_req` is high, set `cand` = next(`ptr`) and go to SEARCH. `sched_req` is ignored while in SEARCH.
  - SEARCH: each cycle examines `cand`, one slot per cycle.
    - If slot `cand` is ready: register `sched_pid` = `cand` and `sched_PC` = PC[`cand`], pulse `sched_valid`, set `ptr` = `cand`, go to IDLE.
    - If NUM_PROC-1 candidates have been examined with none ready: return `sched_pid` = 0 and `sched_PC` = OS_PC, pulse `sched_valid`, leave `ptr` unchanged, go to IDLE.
- **next(x):** x+1, except that NUM_PROC-1 wraps to 1. Slot 0 is never a candidate.
- **Table visibility:** the search reads the table as it stood before the current edge. A write in the same cycle is seen from the next cycle onward.
- **`busy`:** equals (state == SEARCH).

## Timing
- **Reset values:** state IDLE, `ptr` 0, all ready bits 0, all PCs 0, `sched_valid` 0, `sched_pid` 0, `sched_PC` 0, `busy` 0, `cont_trocas` 0, edge register 0.
- **Reset during SEARCH:** the search is aborted and no `sched_valid` is produced.
- **Capture latency:** the table and `cont_trocas` update on the edge that samples the flag's rising transition.
- **Scheduler latency:** if the ready slot found is the k-th candidate, `sched_valid` is high after k+1 edges, counting the edge that sampled `sched_req`.
  - Minimum latency is 2 cycles.
  - Latency with nothing ready is NUM_PROC cycles.
- **`sched_valid`** is high for exactly one cycle. `sched_pid` and `sched_PC` hold their values until the next result.

## Test plan
- **Reset:** hold `reset_geral_n`=0 for 2 cycles with random inputs → all outputs 0 and `ready_mask`=0000. Release reset with the flag already high and `prog_atual`=1 → `cont_trocas`=1.
- **Start and schedule:** start pid1@10 and pid2@40, then pulse `sched_req` → after 2 edges `sched_pid`=1, `sched_PC`=10. Pulse `sched_req` again → after 2 edges `sched_pid`=2, `sched_PC`=40.
- **Capture:** raise the flag for 3 cycles with `prog_atual`=2 and `salva_PC`=57 → PC[2]=57, `cont_trocas`=1 (not 3). Repeat with `prog_atual`=0 → nothing changes.
- **Empty table:** with no ready slots, pulse `sched_req` → after 4 edges `sched_pid`=0, `sched_PC`=3, and `busy` was high for 3 cycles.
- **Wrap-around:** with `ptr`=3 and only slot 1 ready → after 2 edges `sched_pid`=1. With `ptr`=1 and only slot 1 ready → after 4 edges `sched_pid`=1.
- **Conflicts and reset:**
  - Save(pid1, 77) together with end pid1 → slot 1 ready, PC 77.
  - Start and end on pid3 in the same cycle → slot 3 ready.
  - Drive `reset_geral_n` low in the 2nd SEARCH cycle → no `sched_valid` pulse, `busy`=0 on the next cycle.
